// File: rtl/npc_pkg.sv
// Shared NPC core definitions: register-file FSM states and default widths.
package npc_pkg;

  localparam int unsigned NPC_ADDR_WIDTH = 5;
  localparam int unsigned NPC_DATA_WIDTH = 32;

  // CLEAR sweeps every entry to zero after reset; RUN is normal operation.
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-entry busy scoreboard: set on issue, cleared on writeback, looked up per read port.
module rf_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_en,
  input  logic [ADDR_WIDTH-1:0]       set_addr,
  input  logic                        clr_en,
  input  logic [ADDR_WIDTH-1:0]       clr_addr,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD-1:0]            rbusy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Next busy vector: clear first so a same-cycle set on that entry wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_addr != '0) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && set_addr != '0) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port lookup; a forwarded writeback hides the busy bit this cycle.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rbusy[i] = busy_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0 && clr_en && clr_addr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with clear sweep, optional bypass and busy scoreboard.
module regfile_mp
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NPC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = NPC_DATA_WIDTH,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  input  logic                        bset,
  input  logic [ADDR_WIDTH-1:0]       bset_addr,
  output logic [NREAD-1:0]            rbusy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic                  run;
  logic                  wr_en;
  logic [NREAD-1:0]      sb_rbusy;

  assign run   = (state_q == StRun);
  assign ready = run;
  assign wr_en = run && wen && (waddr != '0);

  // Clear-sweep sequencing: walk every entry once, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // FSM state and sweep counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage: sweep writes zeros in CLEAR, the write port is honoured only in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        rf_q[clr_cnt_q] <= '0;
      end else if (wr_en) begin
        rf_q[waddr] <= wdata;
      end
    end
  end

  // Asynchronous read muxes with hardwired-zero entry 0 and optional forwarding.
  always_comb begin
    rdata = '0;
    if (run) begin
      for (int i = 0; i < NREAD; i++) begin
        if (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
          if (BYPASS != 0 && wr_en && waddr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
          end else begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREAD      (NREAD),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (run && bset),
    .set_addr (bset_addr),
    .clr_en   (run && wen),
    .clr_addr (waddr),
    .raddr    (raddr),
    .rbusy    (sb_rbusy)
  );

  assign rbusy = run ? sb_rbusy : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        bset;
  logic [4:0]  bset_addr;

  logic        ready, ready_nb;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NREAD      (2),
    .BYPASS     (1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .bset      (bset),
    .bset_addr (bset_addr),
    .rbusy     (rbusy)
  );

  regfile_mp #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NREAD      (2),
    .BYPASS     (0)
  ) u_dut_nb (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready_nb),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata_nb),
    .bset      (bset),
    .bset_addr (bset_addr),
    .rbusy     (rbusy_nb)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bset;
    logic [4:0]  baddr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;   // expected port data, bypassing instance
    logic [31:0] e1;
    logic [1:0]  eb;   // expected rbusy {port1, port0}
    logic [31:0] n0;   // expected port data, non-bypassing instance
    logic [31:0] n1;
    logic [1:0]  nb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    bset      = 1'b0;
    bset_addr = '0;
  endtask

  // Counts edges after the current point until ready rises; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0,
                 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7,
                 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b01, 32'h0, 32'hDEADBEEF, 2'b01};
    vecs[6]  = '{1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h77, 32'h77, 2'b00, 32'h0, 32'h0, 2'b11};
    vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h77, 32'h77, 2'b00, 32'h77, 32'h77, 2'b00};
    vecs[8]  = '{1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 5'd7, 5'd0,
                 32'h99, 32'h0, 2'b00, 32'h77, 32'h0, 2'b00};
    vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h99, 32'h99, 2'b11, 32'h99, 32'h99, 2'b11};
    vecs[10] = '{1'b1, 5'd9, 32'h5, 1'b1, 5'd9, 5'd9, 5'd7,
                 32'h5, 32'h99, 2'b10, 32'h0, 32'h99, 2'b10};
    vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                 32'h5, 32'h5, 2'b11, 32'h5, 32'h5, 2'b11};

    // Reset then idle sweep.
    idle_inputs();
    raddr = '0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", {63'b0, ready}, 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_rbusy", {62'b0, rbusy}, 64'd0);
    wait_ready(n);
    check("sweep_len", 64'(n), 64'd32);
    check("sweep_len_nb", {63'b0, ready_nb}, 64'd1);

    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(31 - a)};
      #1;
      check($sformatf("zero_read_%0d", a), rdata, 64'd0);
    end

    // Table-driven RUN vectors; a vector's write lands on the edge after its sample.
    for (int v = 0; v < 12; v++) begin
      wen       = vecs[v].wen;
      waddr     = vecs[v].waddr;
      wdata     = vecs[v].wdata;
      bset      = vecs[v].bset;
      bset_addr = vecs[v].baddr;
      raddr     = {vecs[v].ra1, vecs[v].ra0};
      @(negedge clk);
      check($sformatf("vec%0d_rdata", v), rdata, {vecs[v].e1, vecs[v].e0});
      check($sformatf("vec%0d_rbusy", v), {62'b0, rbusy}, {62'b0, vecs[v].eb});
      check($sformatf("vec%0d_rdata_nb", v), rdata_nb, {vecs[v].n1, vecs[v].n0});
      check($sformatf("vec%0d_rbusy_nb", v), {62'b0, rbusy_nb}, {62'b0, vecs[v].nb});
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Mid-sweep reset: restart at clear cycle 10, then a full 32-cycle sweep.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      if (ready) n++;
    end
    check("midsweep_ready_low", 64'(n), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    raddr = {5'd7, 5'd5};
    check("restart_rdata_gated", rdata, 64'd0);

    // Second sweep, with a write and busy-set attempted around cycle 20.
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) begin
        wen       = 1'b1;
        waddr     = 5'd3;
        wdata     = 32'hAA;
        bset      = 1'b1;
        bset_addr = 5'd3;
      end else if (n == 21) begin
        idle_inputs();
      end
      if (ready) break;
    end
    idle_inputs();
    check("restart_sweep_len", 64'(n), 64'd32);

    raddr = {5'd3, 5'd5};
    #1;
    check("entry5_cleared", {32'b0, rdata[31:0]}, 64'd0);
    check("entry3_clear_write_ignored", {32'b0, rdata[63:32]}, 64'd0);
    check("entry3_busy_ignored", {62'b0, rbusy}, 64'd0);
    raddr = {5'd9, 5'd7};
    #1;
    check("busy_reset", {62'b0, rbusy}, 64'd0);
    check("busy_reset_nb", {62'b0, rbusy_nb}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the NPC core, successor to the single-read-port file. Provides NREAD asynchronous read ports, one synchronous write port, optional write-to-read bypass, a hardwired-zero entry 0, and a per-entry busy scoreboard for pipelined hazard detection. After reset, a hardware clear sweep zeroes every entry before `ready` is raised, so architectural state is defined without initial blocks.

## Interface
- ADDR_WIDTH, 5, entry address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, entry width
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports and busy cleared combinationally

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  0 during clear sweep, 1 when file usable
- wen  in  1  write enable
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- raddr  in  NREAD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NREAD*DATA_WIDTH  read data, same packing
- bset  in  1  mark bset_addr busy (issue of an instruction producing that register)
- bset_addr  in  ADDR_WIDTH  address to mark busy
- rbusy  out  NREAD  busy flag of each read port's address

## Operation
- States: CLEAR, RUN. rst=1 at an edge: state<=CLEAR, clr_cnt<=0, all busy bits<=0. Takes priority over everything.
- CLEAR: each cycle writes 0 to rf[clr_cnt], clr_cnt++; at clr_cnt==depth-1 the write happens and state<=RUN. wen and bset ignored. rdata all 0, rbusy all 0, ready=0.
- RUN: ready=1.
  - Write: wen && waddr!=0 -> rf[waddr]<=wdata. Writes to 0 discarded.
  - Read port i: raddr_i==0 -> 0; else if BYPASS && wen && waddr==raddr_i -> wdata; else rf[raddr_i].
  - Scoreboard: bset && bset_addr!=0 -> busy[bset_addr]<=1. wen && waddr!=0 -> busy[waddr]<=0. Same address both: set wins (new producer supersedes). busy[0] constantly 0.
  - rbusy_i = busy[raddr_i]; when BYPASS and wen && waddr==raddr_i!=0, rbusy_i=0 (data is forwarded this cycle). Busy effect of a same-cycle bset is not visible until the next cycle.
- Multiple read ports may read the same address; all return identical data.
- Reset asserted mid-sweep or mid-RUN restarts the sweep from entry 0.

## Timing
- Read: combinational, zero latency. Write visible via rf on the cycle after the edge; via bypass in the same cycle.
- rst sampled high at edge E0 -> entries 0..depth-1 cleared at edges E1..Edepth -> ready=1 after edge Edepth (32 cycles for default parameters) provided rst is low from E1 onward.
- Reset values: ready=0, rdata=0, rbusy=0, state=CLEAR, busy=all 0.
- Single write port: no write-write conflict possible.

## Structure
- Shared package npc_pkg: state enum (CLEAR, RUN); default ADDR_WIDTH/DATA_WIDTH constants shared with the decoder.
- Sub-module rf_scoreboard (busy bit vector, set/clear priority, NREAD lookup with bypass clear) is natural; storage, clear FSM and read muxes stay in regfile_mp.

## Test plan
- Reset then idle: rst high 1 cycle -> ready low exactly 32 cycles then high; every address reads 0x00000000.
- Write/read: wen, waddr=5, wdata=0xDEADBEEF -> same cycle rdata port0 (raddr=5)=0xDEADBEEF via bypass; next cycle both ports at 5 return 0xDEADBEEF; with BYPASS=0, same-cycle read returns old value 0.
- Zero register: wen, waddr=0, wdata=0x12345678 -> raddr=0 returns 0 on all ports; rbusy=0 after bset_addr=0.
- Scoreboard: bset, bset_addr=7 -> next cycle rbusy for raddr=7 is 1; later wen waddr=7 -> rbusy 0 same cycle (BYPASS=1); bset and wen on 7 together -> busy stays 1.
- Mid-sweep reset: rst again at clear cycle 10 -> ready stays low 32 further cycles; earlier-written 0xDEADBEEF at entry 5 reads 0 afterward.
- Writes during CLEAR: wen waddr=3 wdata=0xAA at sweep cycle 20 -> entry 3 reads 0 after ready.
